uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
8N1 UART receiver, the receive-side counterpart of the team's UART transmitter. It oversamples the asynchronous serial line, validates the start bit, samples 8 data bits LSB-first at mid-bit, and checks the stop bit. It presents each byte with a one-cycle valid strobe and drives a busy flag that feeds the transmitter's i_rx_busy input for half-duplex arbitration. Baud timing comes from an instance of the existing BaudTickGen.

Parameters:
CLK_FREQ, 100000000, system clock frequency in Hz.
BAUD_RATE, 115200, line bit rate.
OVERSAMPLING, 16, ticks per bit; must be even and >= 4; passed to BaudTickGen.

Ports:
i_clk  in  1  system clock; all logic on rising edge.
i_aresetn  in  1  asynchronous active-low reset.
i_rx  in  1  asynchronous serial input; idles high.
o_rx_data  out  8  last correctly received byte; holds until the next good frame.
o_rx_valid  out  1  one-cycle pulse; o_rx_data is new in the same cycle.
o_rx_busy  out  1  high while a frame is in progress (START, DATA, STOP).
o_frame_err  out  1  one-cycle pulse when the stop bit samples low.

Behaviour:
- Reset (async, active-low): FSM to IDLE; o_rx_data=0x00, o_rx_valid=0, o_rx_busy=0, o_frame_err=0; synchronizer flops=1; tick_cnt=0, bit_cnt=0. Reset mid-frame aborts the frame with no valid or error pulse.
- i_rx passes through a 2-FF synchronizer (reset to 1). All decisions use the synchronized value rx_s.
- tick = baud_tick from BaudTickGen, at rate BAUD_RATE*OVERSAMPLING.
- IDLE: rx_s==0 -> START, tick_cnt=0. This is detected every clock, not only on a tick.
- START: on each tick, tick_cnt++. At tick_cnt==OVERSAMPLING/2-1:
  - if rx_s==0 -> DATA, tick_cnt=0, bit_cnt=0;
  - else it was a glitch -> IDLE, with no outputs.
- DATA: on each tick, tick_cnt++. At tick_cnt==OVERSAMPLING-1:
  - shifter={rx_s, shifter[7:1]}, tick_cnt=0, bit_cnt++;
  - after the 8th sample (bit_cnt==7 before increment) -> STOP.
- STOP: at tick_cnt==OVERSAMPLING-1:
  - rx_s==1 -> o_rx_data=shifter and o_rx_valid=1 for one clock, -> IDLE;
  - rx_s==0 -> o_frame_err=1 for one clock, o_rx_data unchanged, -> BREAK.
- BREAK: wait for rx_s==1, then -> IDLE. This prevents a held-low line (break) from being re-detected as back-to-back start bits. o_rx_busy is 0 in BREAK.
- Outputs are registered. Valid/err assert on the clock after the stop-sample tick.
- o_rx_busy = (state in START/DATA/STOP), registered; it rises 1 clock after the FSM enters START.
- Back-to-back frames: a falling edge arriving in the same cycle the FSM returns to IDLE is caught on the next clock, with no frame loss.
- Counters: tick_cnt is $clog2(OVERSAMPLING) bits and bit_cnt is 3 bits; neither wraps outside the rules above.
- Timing tolerance: sampling error is at most 1 tick plus 2 synchronizer clocks, so total baud mismatch must stay within +/-3%.

Decomposition:
- Shared package uart_pkg holds:
  - enum rx_state_t {IDLE, START, DATA, STOP, BREAK}, 3-bit logic;
  - constant UART_DATA_BITS=8;
  - the TX statetype, moved into the package later.
- Reuse the existing BaudTickGen as the only sub-module.
- The synchronizer and FSM stay inline; the FSM follows the team's registered-next-state comb/ff split.

Test Plan:
- Reset: hold i_aresetn=0 with i_rx=1 -> all outputs 0, o_rx_data=0x00. Release, idle for 2000 clks -> no pulses.
- Single byte: drive 0xA5 at 868 clk/bit (100 MHz, 115200) -> exactly one o_rx_valid with o_rx_data=0xA5; o_rx_busy high from start edge to stop sample; o_frame_err never asserts.
- Back-to-back: send 0x00, 0xFF, 0x55 with zero idle between stop and next start -> three valid pulses in order with matching data.
- Glitch: pulse i_rx low for 200 clks, less than half a bit -> returns to IDLE; no valid, no err; o_rx_busy high for at most ~450 clks.
- Frame error: send 0x3C with stop bit low, then hold low for 3 bit times, then high -> one o_frame_err, o_rx_data keeps its previous value. A following good 0x81 -> valid with 0x81.
- Mid-frame reset: assert i_aresetn=0 during bit 4 of 0x96, release, then send 0x42 -> only 0x42 reported; no err.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions for the receiver and transmitter.
//   rx_state_t     : receiver FSM states
//   tx_state_t     : transmitter FSM states
//   UART_DATA_BITS : payload bits per frame (8N1)
package uart_pkg;

   localparam int UART_DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } rx_state_t;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side UART bundle.
//   i_rx        : serial line into the receiver (idles high)
//   o_rx_data   : last good byte
//   o_rx_valid  : one-cycle strobe, o_rx_data new in that cycle
//   o_rx_busy   : frame in progress
//   o_frame_err : one-cycle strobe on a low stop bit
// slave  = receiver side, master = line driver / byte consumer.
interface uart_rx_if
   import uart_pkg::*;
();
   logic                      i_rx;
   logic [UART_DATA_BITS-1:0] o_rx_data;
   logic                      o_rx_valid;
   logic                      o_rx_busy;
   logic                      o_frame_err;

   modport slave (
      input  i_rx,
      output o_rx_data,
      output o_rx_valid,
      output o_rx_busy,
      output o_frame_err
   );

   modport master (
      output i_rx,
      input  o_rx_data,
      input  o_rx_valid,
      input  o_rx_busy,
      input  o_frame_err
   );
endinterface

// File: rtl/uart_rx_baud_tick_gen.sv
// BaudTickGen: free-running oversampling tick source.
//   i_clk       : system clock
//   i_aresetn   : async active-low reset
//   o_baud_tick : one-cycle pulse at BAUD_RATE*OVERSAMPLING
// The divisor is rounded to the nearest integer; the residual error is
// absorbed by the receiver's mid-bit sampling margin.
module BaudTickGen #(
   parameter int CLK_FREQ     = 100000000,
   parameter int BAUD_RATE    = 115200,
   parameter int OVERSAMPLING = 16
) (
   input  logic i_clk,
   input  logic i_aresetn,
   output logic o_baud_tick
);

   localparam int TICK_RATE = BAUD_RATE * OVERSAMPLING;
   localparam int DIV       = (CLK_FREQ + TICK_RATE / 2) / TICK_RATE;
   localparam int CW        = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] C_RELOAD = CW'(DIV - 1);

   logic [CW-1:0] r_cnt;
   logic          w_tc;

   assign w_tc        = (r_cnt == '0);
   assign o_baud_tick = w_tc;

   always_ff @(posedge i_clk or negedge i_aresetn) begin
      if (!i_aresetn) begin
         r_cnt <= C_RELOAD;
      end else if (w_tc) begin
         r_cnt <= C_RELOAD;
      end else begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with oversampled mid-bit sampling.
//   i_clk     : system clock
//   i_aresetn : async active-low reset
//   bus       : uart_rx_if.slave (i_rx in; data/valid/busy/frame_err out)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | line high, watching every clock for a falling edge
// START | counting to mid start bit to confirm it is still low
// DATA  | sampling 8 data bits LSB-first, one per bit period
// STOP  | sampling stop bit; high -> byte out, low -> framing error
// BREAK | line held low after a framing error; wait for it to go high
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ     = 100000000,
   parameter int BAUD_RATE    = 115200,
   parameter int OVERSAMPLING = 16
) (
   input  logic     i_clk,
   input  logic     i_aresetn,
   uart_rx_if.slave bus
);

   localparam int TW = $clog2(OVERSAMPLING);
   localparam logic [TW-1:0] C_HALF_M1  = TW'(OVERSAMPLING / 2 - 1);
   localparam logic [TW-1:0] C_FULL_M1  = TW'(OVERSAMPLING - 1);
   localparam logic [2:0]    C_LAST_BIT = 3'(UART_DATA_BITS - 1);

   logic                      w_tick;
   logic                      r_rx_meta;
   logic                      r_rx_s;
   rx_state_t                 r_state,    w_state_nxt;
   logic [TW-1:0]             r_tick_cnt, w_tick_nxt;
   logic [2:0]                r_bit_cnt,  w_bit_nxt;
   logic [UART_DATA_BITS-1:0] r_shift,    w_shift_nxt;
   logic [UART_DATA_BITS-1:0] r_data,     w_data_nxt;
   logic                      r_valid,    w_valid_nxt;
   logic                      r_err,      w_err_nxt;
   logic                      r_busy;

   BaudTickGen #(
      .CLK_FREQ     (CLK_FREQ),
      .BAUD_RATE    (BAUD_RATE),
      .OVERSAMPLING (OVERSAMPLING)
   ) u_baud (
      .i_clk       (i_clk),
      .i_aresetn   (i_aresetn),
      .o_baud_tick (w_tick)
   );

   // Synchronizer resets to the idle (high) level so reset never looks
   // like a start bit.
   always_ff @(posedge i_clk or negedge i_aresetn) begin
      if (!i_aresetn) begin
         r_rx_meta <= 1'b1;
         r_rx_s    <= 1'b1;
      end else begin
         r_rx_meta <= bus.i_rx;
         r_rx_s    <= r_rx_meta;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_tick_nxt  = r_tick_cnt;
      w_bit_nxt   = r_bit_cnt;
      w_shift_nxt = r_shift;
      w_data_nxt  = r_data;
      w_valid_nxt = 1'b0;
      w_err_nxt   = 1'b0;

      case (r_state)
         IDLE: begin
            if (!r_rx_s) begin
               w_state_nxt = START;
               w_tick_nxt  = '0;
            end
         end
         START: begin
            if (w_tick) begin
               if (r_tick_cnt == C_HALF_M1) begin
                  if (!r_rx_s) begin
                     w_state_nxt = DATA;
                     w_tick_nxt  = '0;
                     w_bit_nxt   = '0;
                  end else begin
                     w_state_nxt = IDLE;
                  end
               end else begin
                  w_tick_nxt = r_tick_cnt + 1'b1;
               end
            end
         end
         DATA: begin
            if (w_tick) begin
               if (r_tick_cnt == C_FULL_M1) begin
                  w_shift_nxt = {r_rx_s, r_shift[UART_DATA_BITS-1:1]};
                  w_tick_nxt  = '0;
                  if (r_bit_cnt == C_LAST_BIT) begin
                     w_bit_nxt   = '0;
                     w_state_nxt = STOP;
                  end else begin
                     w_bit_nxt = r_bit_cnt + 3'd1;
                  end
               end else begin
                  w_tick_nxt = r_tick_cnt + 1'b1;
               end
            end
         end
         STOP: begin
            if (w_tick) begin
               if (r_tick_cnt == C_FULL_M1) begin
                  w_tick_nxt = '0;
                  if (r_rx_s) begin
                     w_data_nxt  = r_shift;
                     w_valid_nxt = 1'b1;
                     w_state_nxt = IDLE;
                  end else begin
                     w_err_nxt   = 1'b1;
                     w_state_nxt = BREAK;
                  end
               end else begin
                  w_tick_nxt = r_tick_cnt + 1'b1;
               end
            end
         end
         BREAK: begin
            if (r_rx_s) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_aresetn) begin
      if (!i_aresetn) begin
         r_state    <= IDLE;
         r_tick_cnt <= '0;
         r_bit_cnt  <= '0;
         r_shift    <= '0;
         r_data     <= '0;
         r_valid    <= 1'b0;
         r_err      <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_tick_cnt <= w_tick_nxt;
         r_bit_cnt  <= w_bit_nxt;
         r_shift    <= w_shift_nxt;
         r_data     <= w_data_nxt;
         r_valid    <= w_valid_nxt;
         r_err      <= w_err_nxt;
         // Busy follows the current state, so it lags state entry by a clock.
         r_busy     <= (r_state == START) || (r_state == DATA) || (r_state == STOP);
      end
   end

   assign bus.o_rx_data   = r_data;
   assign bus.o_rx_valid  = r_valid;
   assign bus.o_rx_busy   = r_busy;
   assign bus.o_frame_err = r_err;

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

   localparam int CLK_FREQ = 100000000;
   localparam int BAUD     = 230400;
   localparam int OS       = 16;
   localparam int BIT      = CLK_FREQ / BAUD;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   uart_rx_if bus ();

   uart_rx #(
      .CLK_FREQ     (CLK_FREQ),
      .BAUD_RATE    (BAUD),
      .OVERSAMPLING (OS)
   ) dut (
      .i_clk     (clk),
      .i_aresetn (rst_n),
      .bus       (bus)
   );

   typedef struct packed {
      logic       err;
      logic [7:0] data;
   } exp_t;

   exp_t       sb_q[$];
   exp_t       mon_e;
   logic [7:0] m_last_good = 8'h00;
   int         n_checks = 0;
   int         n_pass   = 0;
   int         busy_run = 0;
   int         busy_max = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
   endtask

   // Monitor: pops the scoreboard on every valid/err strobe.
   always @(negedge clk) begin
      if (bus.o_rx_busy) begin
         busy_run++;
         if (busy_run > busy_max) busy_max = busy_run;
      end else begin
         busy_run = 0;
      end
      if (bus.o_rx_valid || bus.o_frame_err) begin
         if (sb_q.size() == 0) begin
            check("unexpected_out", {30'd0, bus.o_rx_valid, bus.o_frame_err}, 32'd0);
         end else begin
            mon_e = sb_q.pop_front();
            check("out_kind", {30'd0, bus.o_rx_valid, bus.o_frame_err},
                  mon_e.err ? 32'd1 : 32'd2);
            check("out_data", {24'd0, bus.o_rx_data}, {24'd0, mon_e.data});
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive(input logic v, input int n);
      bus.i_rx = v;
      repeat (n) @(negedge clk);
   endtask

   // Reference model: a good stop yields the byte; a bad stop yields an
   // error with the previously reported byte unchanged.
   task automatic send_frame(input logic [7:0] d, input logic stop_ok, input logic chk_busy);
      exp_t e;
      if (stop_ok) begin
         m_last_good = d;
         e = {1'b0, d};
      end else begin
         e = {1'b1, m_last_good};
      end
      sb_q.push_back(e);
      bus.i_rx = 1'b0;
      idle(BIT / 2);
      if (chk_busy) check("busy_start", {31'd0, bus.o_rx_busy}, 32'd1);
      idle(BIT - BIT / 2);
      for (int i = 0; i < 8; i++) begin
         bus.i_rx = d[i];
         idle(BIT / 2);
         if (chk_busy) check("busy_data", {31'd0, bus.o_rx_busy}, 32'd1);
         idle(BIT - BIT / 2);
      end
      bus.i_rx = stop_ok;
      idle(BIT / 4);
      if (chk_busy) check("busy_stop", {31'd0, bus.o_rx_busy}, 32'd1);
      idle(BIT - BIT / 4);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [7:0] d;
      logic       ok;
      int         n;

      bus.i_rx = 1'b1;
      rst_n    = 1'b0;
      idle(5);
      check("rst_data",  {24'd0, bus.o_rx_data}, 32'd0);
      check("rst_valid", {31'd0, bus.o_rx_valid}, 32'd0);
      check("rst_busy",  {31'd0, bus.o_rx_busy}, 32'd0);
      check("rst_err",   {31'd0, bus.o_frame_err}, 32'd0);
      rst_n    = 1'b1;
      busy_max = 0;
      idle(2000);
      check("idle_busy", busy_max, 32'd0);

      // Single byte with busy tracking
      send_frame(8'hA5, 1'b1, 1'b1);
      check("busy_after_stop", {31'd0, bus.o_rx_busy}, 32'd0);
      check("single_popped", sb_q.size(), 32'd0);
      idle(BIT);

      // Back-to-back, no idle
      send_frame(8'h00, 1'b1, 1'b0);
      send_frame(8'hFF, 1'b1, 1'b0);
      send_frame(8'h55, 1'b1, 1'b0);
      drive(1'b1, BIT);
      check("b2b_popped", sb_q.size(), 32'd0);

      // Glitch shorter than half a bit
      busy_max = 0;
      drive(1'b0, BIT / 4);
      drive(1'b1, 2 * BIT);
      check("glitch_seen", {31'd0, busy_max > 0}, 32'd1);
      check("glitch_busy_bound", {31'd0, busy_max <= (BIT * 9) / 16}, 32'd1);
      check("glitch_data_hold", {24'd0, bus.o_rx_data}, 32'h55);

      // Framing error followed by a held-low line
      send_frame(8'h3C, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         idle(BIT / 2);
         check("break_busy", {31'd0, bus.o_rx_busy}, 32'd0);
         idle(BIT - BIT / 2);
      end
      drive(1'b1, BIT);
      check("err_data_hold", {24'd0, bus.o_rx_data}, 32'h55);
      send_frame(8'h81, 1'b1, 1'b0);
      drive(1'b1, BIT);

      // Reset in the middle of bit 4 of 0x96; nothing expected from it
      d = 8'h96;
      drive(1'b0, BIT);
      for (int i = 0; i < 4; i++) drive(d[i], BIT);
      drive(d[4], BIT / 2);
      rst_n = 1'b0;
      m_last_good = 8'h00;
      idle(10);
      bus.i_rx = 1'b1;
      idle(5);
      check("midrst_data", {24'd0, bus.o_rx_data}, 32'd0);
      check("midrst_busy", {31'd0, bus.o_rx_busy}, 32'd0);
      rst_n = 1'b1;
      idle(BIT);
      send_frame(8'h42, 1'b1, 1'b0);
      drive(1'b1, BIT);

      // Randomized frames
      for (int k = 0; k < 4; k++) begin
         d  = 8'($urandom);
         ok = ($urandom_range(0, 3) != 0);
         send_frame(d, ok, 1'b0);
         if (ok) begin
            n = $urandom_range(0, BIT / 2);
            drive(1'b1, n);
         end else begin
            n = $urandom_range(BIT / 2, 2 * BIT);
            drive(1'b0, n);
            n = $urandom_range(4, BIT);
            drive(1'b1, n);
         end
      end
      bus.i_rx = 1'b1;

      for (int i = 0; i < 2 * BIT && sb_q.size() != 0; i++) @(negedge clk);
      check("sb_drained", sb_q.size(), 32'd0);
      idle(20);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
